// File: rtl/imm_gen_fifo_pkg.sv
// imm_pkg: immediate-generation types and helpers shared by the immediate FIFO and IDU.
//   IMM_I..IMM_J   bit positions inside the one-hot type vector {J,U,B,S,I}
//   imm_type_t     5-bit one-hot immediate type
//   imm_extract()  AND-OR select of the sign-extended immediate (64 bits; callers
//                  keep the low XLEN bits, which is still a correct sign extension)
//   imm_multi_hot() true when more than one type bit is set
package imm_pkg;

  localparam int IMM_I      = 0;
  localparam int IMM_S      = 1;
  localparam int IMM_B      = 2;
  localparam int IMM_U      = 3;
  localparam int IMM_J      = 4;
  localparam int IMM_TYPE_W = 5;
  localparam int IMM_MAX_W  = 64;

  typedef logic [IMM_TYPE_W-1:0] imm_type_t;

  function automatic logic [IMM_MAX_W-1:0] imm_extract(input logic [31:0] inst,
                                                       input imm_type_t   typ);
    logic [IMM_MAX_W-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    i_imm = {{52{inst[31]}}, inst[31:20]};
    s_imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    b_imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    u_imm = {{32{inst[31]}}, inst[31:12], 12'h000};
    j_imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    // no priority: a multi-hot type yields the OR of the selected terms
    return ({IMM_MAX_W{typ[IMM_I]}} & i_imm) |
           ({IMM_MAX_W{typ[IMM_S]}} & s_imm) |
           ({IMM_MAX_W{typ[IMM_B]}} & b_imm) |
           ({IMM_MAX_W{typ[IMM_U]}} & u_imm) |
           ({IMM_MAX_W{typ[IMM_J]}} & j_imm);
  endfunction

  function automatic logic imm_multi_hot(input imm_type_t typ);
    return (typ & (typ - 5'd1)) != '0;
  endfunction

endpackage

// File: rtl/imm_gen_fifo_if.sv
// imm_gen_fifo_if: decode-side push and execute-side pop handshakes of the immediate FIFO.
//   flush                      pipeline redirect, clears the FIFO
//   in_valid/in_ready          push handshake; in_inst, in_type carry the raw instruction
//   out_valid/out_ready        pop handshake; out_imm, out_type carry the head entry
// master: the decode/execute pipeline around the FIFO; slave: the FIFO itself.
interface imm_gen_fifo_if #(parameter int XLEN = 64);
  import imm_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  imm_type_t       in_type;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  imm_type_t       out_type;

  modport master (
    output flush, in_valid, in_inst, in_type, out_ready,
    input  in_ready, out_valid, out_imm, out_type
  );

  modport slave (
    input  flush, in_valid, in_inst, in_type, out_ready,
    output in_ready, out_valid, out_imm, out_type
  );

endinterface

// File: rtl/imm_gen_fifo_mem.sv
// imm_fifo_mem: DEPTH x WIDTH register array for the immediate FIFO.
//   clk, rst_n      clock, async active-low reset (clears every entry)
//   we/waddr/wdata  synchronous write port
//   raddr/rdata     asynchronous read port
// Clearing the array on reset makes the head read back as zero right after reset.
module imm_fifo_mem #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 69
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imm_gen_fifo.sv
// imm_gen_fifo: extracts the RISC-V I/S/B/U/J immediate from a 32-bit instruction under a
// one-hot type vector and buffers {type, immediate} in a DEPTH-entry FIFO between IDU decode
// and the EXU operand stage.
//   clk, rst_n  clock, async active-low reset
//   bus         imm_gen_fifo_if.slave: flush, push side (in_*), pop side (out_*)
//   type_err    only with IMM_ONEHOT_CHK_EN defined: one-cycle pulse after a multi-hot push
// Parameters: XLEN (32 or 64) immediate width, DEPTH (power of two, >= 2) entries.
module imm_gen_fifo
  import imm_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_gen_fifo_if.slave bus
`ifdef IMM_ONEHOT_CHK_EN
  ,
  output logic          type_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = XLEN + IMM_TYPE_W;

  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 full, empty, push, pop;
  logic [IMM_MAX_W-1:0] imm_full;
  logic [EW-1:0]        wr_entry, rd_entry;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // in_ready comes only from stored state, so a pop while full cannot admit a push the same cycle
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;

  assign push = bus.in_valid && !full;
  assign pop  = !empty && bus.out_ready;

  assign imm_full = imm_extract(bus.in_inst, bus.in_type);
  assign wr_entry = {bus.in_type, imm_full[XLEN-1:0]};

  imm_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push && !bus.flush),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign bus.out_imm  = rd_entry[XLEN-1:0];
  assign bus.out_type = rd_entry[EW-1:XLEN];

  // pointers wrap on their own since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef IMM_ONEHOT_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) type_err <= 1'b0;
    else        type_err <= push && !bus.flush && imm_multi_hot(bus.in_type);
  end

`ifndef SYNTHESIS
  // multi-hot entries are still stored with the OR value, so this only warns
  a_onehot_push: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> !imm_multi_hot(bus.in_type))
    else $warning("imm_gen_fifo: multi-hot in_type pushed");
`endif
`endif

endmodule

// File: tb/tb_imm_gen_fifo.sv
module tb_imm_gen_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  imm_gen_fifo_if #(.XLEN(64)) bus ();

`ifdef IMM_ONEHOT_CHK_EN
  logic type_err;
  imm_gen_fifo #(.XLEN(64), .DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .type_err(type_err));
`else
  imm_gen_fifo #(.XLEN(64), .DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_total++; if (bus.out_imm !== 64'h0) $display("FAIL rst_out_imm got %h want 0", bus.out_imm); else n_pass++;
    n_total++; if (bus.out_type !== 5'b0) $display("FAIL rst_out_type got %b want 0", bus.out_type); else n_pass++;
`ifdef IMM_ONEHOT_CHK_EN
    n_total++; if (type_err !== 1'b0) $display("FAIL rst_type_err got %b want 0", type_err); else n_pass++;
`endif
  endtask

  // called at a negedge with an empty FIFO
  task automatic test_single(input string name, input logic [31:0] inst, input logic [4:0] typ,
                             input logic [63:0] exp, input logic exp_err);
    bus.in_valid = 1'b1; bus.in_inst = inst; bus.in_type = typ; bus.out_ready = 1'b1;
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL %s_passthru out_valid got %b want 0", name, bus.out_valid); else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL %s_valid got %b want 1", name, bus.out_valid); else n_pass++;
    n_total++; if (bus.out_imm !== exp) $display("FAIL %s_imm got %h want %h", name, bus.out_imm, exp); else n_pass++;
    n_total++; if (bus.out_type !== typ) $display("FAIL %s_type got %b want %b", name, bus.out_type, typ); else n_pass++;
`ifdef IMM_ONEHOT_CHK_EN
    n_total++; if (type_err !== exp_err) $display("FAIL %s_type_err got %b want %b", name, type_err, exp_err); else n_pass++;
`endif
    tick();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL %s_drain out_valid got %b want 0", name, bus.out_valid); else n_pass++;
`ifdef IMM_ONEHOT_CHK_EN
    n_total++; if (type_err !== 1'b0) $display("FAIL %s_type_err_clr got %b want 0", name, type_err); else n_pass++;
`else
    if (exp_err) begin end
`endif
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_type = 5'b01000; bus.in_inst = 32'h11111037;
    tick();
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready1 got %b want 1", bus.in_ready); else n_pass++;
    n_total++; if (bus.out_imm !== 64'h11111000) $display("FAIL bp_head1 got %h want %h", bus.out_imm, 64'h11111000); else n_pass++;
    bus.in_inst = 32'h22222037;
    tick();
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_full got %b want 0", bus.in_ready); else n_pass++;
    bus.in_inst = 32'h33333037;
    tick();
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_held got %b want 0", bus.in_ready); else n_pass++;
    tick();
    n_total++; if (bus.out_imm !== 64'h11111000) $display("FAIL bp_stable got %h want %h", bus.out_imm, 64'h11111000); else n_pass++;
    bus.out_ready = 1'b1;
    tick();
    n_total++; if (bus.out_imm !== 64'h22222000) $display("FAIL bp_head2 got %h want %h", bus.out_imm, 64'h22222000); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_slot_free got %b want 1", bus.in_ready); else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.out_imm !== 64'h33333000) $display("FAIL bp_head3 got %h want %h", bus.out_imm, 64'h33333000); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid3 got %b want 1", bus.out_valid); else n_pass++;
    tick();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", bus.out_valid); else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [63:0] q[$];
    logic [63:0] exp;
    int sent = 0;
    int rcvd = 0;
    int cyc = 0;
    bus.in_type = 5'b01000;
    while (rcvd < 10 && cyc < 60) begin
      bus.out_ready = (cyc % 3) != 2;
      bus.in_valid  = sent < 10;
      bus.in_inst   = {20'(sent + 1), 12'h037};
      exp           = {32'h0, 20'(sent + 1), 12'h000};
      #1;
      if (bus.out_valid && bus.out_ready) begin
        n_total++;
        if (q.size() == 0) $display("FAIL wrap_pop got %h want none (model empty)", bus.out_imm);
        else if (bus.out_imm !== q[0]) $display("FAIL wrap_pop%0d got %h want %h", rcvd, bus.out_imm, q[0]);
        else n_pass++;
        if (q.size() != 0) void'(q.pop_front());
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(exp);
        sent++;
      end
      tick();
      cyc++;
    end
    n_total++; if (rcvd != 10) $display("FAIL wrap_count got %0d want 10", rcvd); else n_pass++;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_type = 5'b01000;
    bus.in_inst = 32'h44444037; tick();
    bus.in_inst = 32'h55555037; tick();
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL fl_full got %b want 0", bus.in_ready); else n_pass++;
    bus.in_inst = 32'h66666037; bus.out_ready = 1'b1; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL fl_valid got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL fl_ready got %b want 1", bus.in_ready); else n_pass++;
    bus.in_valid = 1'b1; bus.in_inst = 32'h77777037;
    tick();
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL fl_count1 in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_total++; if (bus.out_imm !== 64'h77777000) $display("FAIL fl_head got %h want %h", bus.out_imm, 64'h77777000); else n_pass++;
    // one entry held, push and pop both enabled, flush wins
    bus.in_inst = 32'h88888037; bus.out_ready = 1'b1; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL fl_pp_valid got %b want 0", bus.out_valid); else n_pass++;
    bus.in_inst = 32'h99999037;
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.out_imm !== 64'hFFFF_FFFF_9999_9000) $display("FAIL fl_after got %h want %h", bus.out_imm, 64'hFFFF_FFFF_9999_9000); else n_pass++;
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL fl_drain got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1; bus.in_type = 5'b00001; bus.in_inst = 32'h7FF00093;
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL rm_pre got %b want 1", bus.out_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rm_valid got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rm_ready got %b want 1", bus.in_ready); else n_pass++;
    n_total++; if (bus.out_imm !== 64'h0) $display("FAIL rm_imm got %h want 0", bus.out_imm); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rm_after got %b want 0", bus.out_valid); else n_pass++;
  endtask

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_type = '0; bus.out_ready = 1'b0;
    #3 rst_n = 1'b0;
    tick();
    test_reset();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_single("imm_i",  32'hFFF00093, 5'b00001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    test_single("imm_s",  32'h0020B423, 5'b00010, 64'h0000_0000_0000_0008, 1'b0);
    test_single("imm_b",  32'hFE000EE3, 5'b00100, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    test_single("imm_u1", 32'h80000037, 5'b01000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    test_single("imm_u2", 32'h12345037, 5'b01000, 64'h0000_0000_1234_5000, 1'b0);
    test_single("imm_j",  32'h0080006F, 5'b10000, 64'h0000_0000_0000_0008, 1'b0);
    test_single("imm_is", 32'h0020B423, 5'b00011, 64'h0000_0000_0000_000A, 1'b1);
    test_single("imm_0",  32'hFFF00093, 5'b00000, 64'h0000_0000_0000_0000, 1'b0);
    test_backpressure();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
